pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Slew-rate controller feeding the 8-bit duty input of the PWM generator.
//  Accepts a target duty over a valid/ready handshake and moves duty_out toward it
//  in bounded steps, changing it only on PWM period boundaries so output stays glitch-free.
//  Owns the period counter and exports period_start so the PWM datapath stays aligned.
// PARAMETERS
//  DUTY_W    8       width of duty/target values
//  PERIOD    131072  clocks per PWM period (>=2)
//  STEP      1       max duty change per ramp event (1..2^DUTY_W-1)
//  RAMP_DIV  1       periods between ramp events (>=1)
// PORTS
//  clk           in   1       system clock, all logic on posedge
//  rst_n         in   1       synchronous reset, active low
//  tgt_valid     in   1       new target offered
//  tgt_ready     out  1       target can be accepted this cycle
//  tgt_duty      in   DUTY_W  requested duty
//  estop         in   1       emergency stop (PWM_ESTOP_EN only)
//  duty_out      out  DUTY_W  duty value to PWM generator
//  period_start  out  1       1-cycle strobe on first clock of each period
//  busy          out  1       ramp in progress (state UP or DOWN)
//  done          out  1       1-cycle strobe when duty_out reaches target
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): duty_out=0, target=0, period cnt=0, div cnt=0,
//    period_start=0, busy=0, done=0, tgt_ready=0 that cycle, state=IDLE. Mid-ramp reset
//    aborts immediately; no residual step.
//  - Period cnt: 0..PERIOD-1 wraps; period_start=1 registered when cnt==0 (first period
//    strobe is PERIOD cycles after reset release, not at release).
//  - Ramp event: every RAMP_DIV-th period_start (div cnt wraps 0..RAMP_DIV-1).
//  - Handshake: tgt_ready=1 in IDLE/UP/DOWN out of reset; transfer on tgt_valid&&tgt_ready;
//    target register updates next clock. Back-to-back transfers allowed; last wins.
//  - Acceptance in same cycle as a ramp event: event uses old target; new one from next event.
//  - States: IDLE (duty_out==target), UP (duty_out<target), DOWN (duty_out>target).
//    State re-evaluated every clock from target vs duty_out; duty_out moves only on events.
//  - On event in UP: duty_out += min(STEP, target-duty_out); DOWN: -= min(STEP, duty_out-target).
//    Arithmetic in DUTY_W+1 bits; no overshoot, no wrap past 0 or 2^DUTY_W-1.
//  - done=1 for one cycle on the clock duty_out becomes equal to target via a step.
//    Target set equal to current duty_out: no step, no done.
//  - busy = state in {UP,DOWN}; goes 0 the same cycle done pulses.
//  - Latency: accepted target -> first duty change at next ramp event (<= PERIOD*RAMP_DIV+1).
// CONFIGURATION
//  PWM_ESTOP_EN defined: estop port exists. estop=1 -> next clock duty_out=0, target=0,
//   state ESTOP, busy=0, tgt_ready=0, no done; held while estop=1 (period cnt keeps running).
//   estop falls -> IDLE next clock, tgt_ready=1. estop wins over simultaneous tgt transfer.
//  PWM_ESTOP_EN undefined: no estop port, no ESTOP state; all else identical.
// TESTING (PERIOD=16, STEP=4, RAMP_DIV=1 unless stated)
//  1 Reset: hold rst_n=0 4 clks mid-ramp (duty 40->200) -> duty_out=0, busy=0, done=0,
//    period_start first at 16 clks after release.
//  2 Up ramp: tgt 0->10 -> duty_out 4,8,10 on 3 successive period_starts; done once with 10; busy 0.
//  3 Down + saturate: from 255 tgt 0, STEP=255 -> duty_out 0 in one event, no wrap; done=1.
//  4 Retarget: ramping 0->100, at duty 20 send tgt 12 -> next event duty 16, then 12, done;
//    tgt sent in event cycle -> that event still steps toward old target.
//  5 RAMP_DIV=3, tgt 8 -> steps only every 48 clks: 4 at 3rd strobe, 8 at 6th.
//  6 PWM_ESTOP_EN: estop=1 at duty 60 -> duty_out 0 next clk, tgt_ready 0; release -> IDLE, ready 1.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slew-rate limiter for the PWM duty input.
// Accepts a target duty over valid/ready and walks o_duty_out toward it in
// steps of at most STEP, only on ramp events (every RAMP_DIV-th period start),
// so the PWM generator never sees a mid-period duty change.
// Optional feature macro: PWM_ESTOP_EN adds the i_estop port and ESTOP state.
module pwm_ramp_ctrl #(
    parameter int DUTY_W   = 8,
    parameter int PERIOD   = 131072,
    parameter int STEP     = 1,
    parameter int RAMP_DIV = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tgt_valid,
    output logic              o_tgt_ready,
    input  logic [DUTY_W-1:0] i_tgt_duty,
`ifdef PWM_ESTOP_EN
    input  logic              i_estop,
`endif
    output logic [DUTY_W-1:0] o_duty_out,
    output logic              o_period_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);

`ifdef PWM_ESTOP_EN
    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_ESTOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;
`endif

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic                r_period_start;
    logic [DUTY_W-1:0]   r_duty;
    logic [DUTY_W-1:0]   r_tgt;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic                w_wrap;
    logic                w_event;
    logic                w_accept;
    logic [DUTY_W-1:0]   w_tgt_nxt;
    logic [DUTY_W-1:0]   w_duty_nxt;
    logic                w_stepped;

    // Step up by min(STEP, gap); the extra bit keeps the gap and sum from wrapping.
    function automatic logic [DUTY_W-1:0] f_step_up(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] gap;
        logic [DUTY_W:0] inc;
        logic [DUTY_W:0] sum;
        gap = {1'b0, tgt} - {1'b0, cur};
        inc = (gap < STEP_X) ? gap : STEP_X;
        sum = {1'b0, cur} + inc;
        return DUTY_W'(sum);
    endfunction

    // Step down by min(STEP, gap); never goes below the target, so never below 0.
    function automatic logic [DUTY_W-1:0] f_step_down(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] gap;
        logic [DUTY_W:0] dec;
        logic [DUTY_W:0] dif;
        gap = {1'b0, cur} - {1'b0, tgt};
        dec = (gap < STEP_X) ? gap : STEP_X;
        dif = {1'b0, cur} - dec;
        return DUTY_W'(dif);
    endfunction

    // Next-value logic: ramp event detection, handshake and the duty step.
    always_comb begin
        w_wrap     = (r_cnt == CNT_W'(PERIOD - 1));
        w_event    = w_wrap && (r_div == DIV_W'(RAMP_DIV - 1));
        w_accept   = i_tgt_valid && r_ready;
        w_tgt_nxt  = w_accept ? i_tgt_duty : r_tgt;
        w_duty_nxt = r_duty;
        // The step always uses the target held before this clock, so a target
        // accepted on the event clock only takes effect from the next event.
        if (w_event) begin
            case (r_state)
                S_UP:    w_duty_nxt = f_step_up(r_duty, r_tgt);
                S_DOWN:  w_duty_nxt = f_step_down(r_duty, r_tgt);
                default: w_duty_nxt = r_duty;
            endcase
        end
        w_stepped  = (w_duty_nxt != r_duty);
    end

    // Period and ramp-divider counters; they keep running through an estop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt          <= '0;
            r_div          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_period_start <= w_wrap;
            if (w_wrap) begin
                r_div <= (r_div == DIV_W'(RAMP_DIV - 1)) ? '0 : r_div + DIV_W'(1);
            end
        end
    end

    // Ramp FSM: state follows target vs duty after this clock's updates.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef PWM_ESTOP_EN
        end else if (i_estop) begin
            r_state <= S_ESTOP;
            r_duty  <= '0;
            r_tgt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`endif
        end else begin
            r_duty  <= w_duty_nxt;
            r_tgt   <= w_tgt_nxt;
            r_ready <= 1'b1;
            r_done  <= w_stepped && (w_duty_nxt == w_tgt_nxt);
            if (w_tgt_nxt > w_duty_nxt) begin
                r_state <= S_UP;
                r_busy  <= 1'b1;
            end else if (w_tgt_nxt < w_duty_nxt) begin
                r_state <= S_DOWN;
                r_busy  <= 1'b1;
            end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign o_tgt_ready    = r_ready;
    assign o_duty_out     = r_duty;
    assign o_period_start = r_period_start;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: two instances (fine-step and one-shot/divided),
// a rule-level reference model compared every cycle, directed literal checks
// and a randomized phase.
module tb_pwm_ramp_ctrl;

    localparam int P0 = 16, S0 = 4,   R0 = 1;
    localparam int P1 = 6,  S1 = 255, R1 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld  [2];
    logic [7:0] dd   [2];
    logic       rdy  [2];
    logic [7:0] duty [2];
    logic       ps   [2];
    logic       busy [2];
    logic       done [2];
`ifdef PWM_ESTOP_EN
    logic       estop;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.DUTY_W(8), .PERIOD(P0), .STEP(S0), .RAMP_DIV(R0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tgt_valid(vld[0]), .o_tgt_ready(rdy[0]),
        .i_tgt_duty(dd[0]),
`ifdef PWM_ESTOP_EN
        .i_estop(estop),
`endif
        .o_duty_out(duty[0]), .o_period_start(ps[0]), .o_busy(busy[0]), .o_done(done[0]));

    pwm_ramp_ctrl #(.DUTY_W(8), .PERIOD(P1), .STEP(S1), .RAMP_DIV(R1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tgt_valid(vld[1]), .o_tgt_ready(rdy[1]),
        .i_tgt_duty(dd[1]),
`ifdef PWM_ESTOP_EN
        .i_estop(estop),
`endif
        .o_duty_out(duty[1]), .o_period_start(ps[1]), .o_busy(busy[1]), .o_done(done[1]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: clocks counted since reset release decide strobes and events.
    int m_cyc [2], m_duty [2], m_tgt [2];
    bit m_rdy [2], m_ps [2], m_busy [2], m_done [2];
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int p, s, r, nd, nt, g;
            bit ev, acc;
            p = (i == 0) ? P0 : P1;
            s = (i == 0) ? S0 : S1;
            r = (i == 0) ? R0 : R1;
            if (!rst_n) begin
                m_cyc[i] = 0; m_duty[i] = 0; m_tgt[i] = 0; m_rdy[i] = 0;
                m_ps[i] = 0; m_busy[i] = 0; m_done[i] = 0;
            end else begin
                m_cyc[i] = m_cyc[i] + 1;
                m_ps[i]  = (m_cyc[i] % p == 0);
                ev       = m_ps[i] && ((m_cyc[i] / p) % r == 0);
                acc      = vld[i] && m_rdy[i];
`ifdef PWM_ESTOP_EN
                if (estop) begin
                    m_duty[i] = 0; m_tgt[i] = 0; m_rdy[i] = 0; m_busy[i] = 0; m_done[i] = 0;
                end else
`endif
                begin
                    nd = m_duty[i];
                    if (ev && m_duty[i] < m_tgt[i]) begin
                        g  = m_tgt[i] - m_duty[i];
                        nd = m_duty[i] + ((g < s) ? g : s);
                    end else if (ev && m_duty[i] > m_tgt[i]) begin
                        g  = m_duty[i] - m_tgt[i];
                        nd = m_duty[i] - ((g < s) ? g : s);
                    end
                    nt = acc ? int'(dd[i]) : m_tgt[i];
                    m_done[i] = (nd != m_duty[i]) && (nd == nt);
                    m_duty[i] = nd;
                    m_tgt[i]  = nt;
                    m_busy[i] = (nd != nt);
                    m_rdy[i]  = 1'b1;
                end
            end
        end
        if (!rst_n) chk_en = 1'b1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d.duty", i),  int'(duty[i]), m_duty[i]);
                chk($sformatf("dut%0d.pstart", i), int'(ps[i]),  int'(m_ps[i]));
                chk($sformatf("dut%0d.busy", i),  int'(busy[i]), int'(m_busy[i]));
                chk($sformatf("dut%0d.done", i),  int'(done[i]), int'(m_done[i]));
                chk($sformatf("dut%0d.ready", i), int'(rdy[i]),  int'(m_rdy[i]));
            end
        end
    end

    // Called at a negedge; holds valid until a clock with ready high.
    task automatic send(input int i, input int val);
        vld[i] = 1'b1;
        dd[i]  = 8'(val);
        for (int k = 0; k < 50; k++) begin
            if (rdy[i]) begin
                @(negedge clk);
                vld[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        vld[i] = 1'b0;
        chk("send_timeout", 0, 1);
    endtask

    task automatic wait_duty(input int i, input int val, input int maxc, input string nm);
        for (int k = 0; k < maxc; k++) begin
            if (int'(duty[i]) == val) return;
            @(negedge clk);
        end
        chk(nm, int'(duty[i]), val);
    endtask

    task automatic wait_ps(input int i, input string nm);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ps[i]) return;
        end
        chk(nm, 0, 1);
    endtask

    initial begin
        int n, dcnt;
        int vals [3];
        rst_n = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0; dd[0] = 8'd0; dd[1] = 8'd0;
`ifdef PWM_ESTOP_EN
        estop = 1'b0;
`endif
        repeat (4) @(negedge clk);
        chk("reset_ready", int'(rdy[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mid-ramp reset: 40 -> 200 interrupted.
        send(0, 40);
        wait_duty(0, 40, 400, "ramp_to_40");
        send(0, 200);
        repeat (40) @(negedge clk);
        chk("midramp_moving", int'(duty[0] > 8'd40), 1);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_duty", int'(duty[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ps[0]) begin n = k; break; end
        end
        chk("first_pstart_clks", n, 16);

        // Up ramp 0 -> 10 with STEP 4.
        send(0, 10);
        dcnt = 0;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done[0]) dcnt++;
                if (ps[0]) break;
            end
            vals[j] = int'(duty[0]);
        end
        chk("up_step1", vals[0], 4);
        chk("up_step2", vals[1], 8);
        chk("up_step3", vals[2], 10);
        chk("up_done_count", dcnt, 1);
        chk("up_busy_end", int'(busy[0]), 0);

        // One-shot saturation on the STEP=255 instance.
        send(1, 255);
        wait_duty(1, 255, 100, "sat_up");
        chk("sat_up_done", int'(done[1]), 1);
        send(1, 0);
        wait_duty(1, 0, 100, "sat_down");
        chk("sat_down_done", int'(done[1]), 1);
        chk("sat_down_busy", int'(busy[1]), 0);

        // Retarget mid-ramp: 10 -> 100, redirect to 12 at duty 18.
        send(0, 100);
        wait_duty(0, 18, 200, "retarget_reach18");
        send(0, 12);
        wait_ps(0, "retarget_ps1");
        chk("retarget_step1", int'(duty[0]), 14);
        wait_ps(0, "retarget_ps2");
        chk("retarget_step2", int'(duty[0]), 12);
        chk("retarget_done", int'(done[0]), 1);

        // Target accepted on the event clock: event still uses old target.
        send(0, 40);
        wait_ps(0, "evt_ps1");
        chk("evt_pre", int'(duty[0]), 16);
        repeat (15) @(negedge clk);
        send(0, 0);
        chk("evt_old_target", int'(duty[0]), 20);
        wait_ps(0, "evt_ps2");
        chk("evt_new_target", int'(duty[0]), 16);

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom % 700 != 0);
`ifdef PWM_ESTOP_EN
            if ($urandom % 60 == 0) estop = ~estop;
`endif
            for (int i = 0; i < 2; i++) begin
                int pick;
                vld[i] = ($urandom % 6 == 0);
                pick   = $urandom % 4;
                dd[i]  = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : 8'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
